// File: rtl/seq_pkg.sv
// Shared types and default widths for the program sequencer.
package seq_pkg;

  localparam int unsigned DefaultPcW  = 10;
  localparam int unsigned DefaultCntW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMemWait,
    StDone
  } seq_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Branch-condition evaluation and next-PC selection (purely combinational).
module next_pc_calc #(
  parameter int unsigned PC_W = seq_pkg::DefaultPcW
) (
  input  logic [PC_W-1:0] pc,
  input  logic            abs_branch,
  input  logic            rel_branch,
  input  logic            branch_invert,
  input  logic            branch_flag,
  input  logic            zero_flag,
  input  logic            neg_flag,
  input  logic [PC_W-1:0] abs_target,
  input  logic [7:0]      rel_offset,
  output logic [PC_W-1:0] next_pc
);

  logic            taken;
  logic [PC_W-1:0] rel_ext;

  // Absolute beats relative; all sums wrap at PC_W bits.
  always_comb begin
    taken   = (branch_flag ? neg_flag : zero_flag) ^ branch_invert;
    rel_ext = PC_W'($signed(rel_offset));
    next_pc = pc + PC_W'(1);
    if (abs_branch && taken) begin
      next_pc = abs_target;
    end else if (rel_branch && taken) begin
      next_pc = pc + rel_ext;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: fetch/execute FSM, PC register and retired-instruction counter.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W  = DefaultPcW,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             AbsBranch,
  input  logic             RelBranch,
  input  logic             BranchInvert,
  input  logic             BranchFlag,
  input  logic             ZeroFlag,
  input  logic             NegFlag,
  input  logic [PC_W-1:0]  AbsTarget,
  input  logic [7:0]       RelOffset,
  input  logic             MemReq,
  input  logic             MemAck,
  input  logic             HaltInstr,
  output logic [PC_W-1:0]  PC,
  output logic             IrLoad,
  output logic             Commit,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  seq_state_e       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  next_pc;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  next_pc_calc #(
    .PC_W(PC_W)
  ) u_next_pc_calc (
    .pc           (pc_q),
    .abs_branch   (AbsBranch),
    .rel_branch   (RelBranch),
    .branch_invert(BranchInvert),
    .branch_flag  (BranchFlag),
    .zero_flag    (ZeroFlag),
    .neg_flag     (NegFlag),
    .abs_target   (AbsTarget),
    .rel_offset   (RelOffset),
    .next_pc      (next_pc)
  );

  // Saturating increment of the retired-instruction counter.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Sequencer FSM with PC and counter updates.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          state_q <= StExec;
        end
        StExec: begin
          if (HaltInstr) begin
            cnt_q   <= cnt_inc;
            state_q <= StDone;
          end else if (MemReq) begin
            // PC and count advance only once the memory access completes.
            state_q <= StMemWait;
          end else begin
            pc_q    <= next_pc;
            cnt_q   <= cnt_inc;
            state_q <= StFetch;
          end
        end
        StMemWait: begin
          if (MemAck) begin
            pc_q    <= pc_q + PC_W'(1);
            cnt_q   <= cnt_inc;
            state_q <= StFetch;
          end
        end
        StDone: begin
          // A new run needs Start to drop first.
          if (!Start) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output decode from the state register; Commit also qualifies on the halt decode.
  always_comb begin
    PC         = pc_q;
    InstrCount = cnt_q;
    IrLoad     = (state_q == StFetch);
    Commit     = (state_q == StExec) && !HaltInstr;
    Busy       = (state_q == StFetch) || (state_q == StExec) || (state_q == StMemWait);
    Done       = (state_q == StDone);
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: driver pushes expected fetches/done events, monitor pops.
module tb_prog_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n, Start, AbsBranch, RelBranch, BranchInvert, BranchFlag;
  logic       ZeroFlag, NegFlag, MemReq, MemAck, HaltInstr;
  logic [9:0] AbsTarget;
  logic [7:0] RelOffset;
  logic [9:0] PC, PC_s;
  logic       IrLoad, Commit, Busy, Done;
  logic       IrLoad_s, Commit_s, Busy_s, Done_s;
  logic [15:0] InstrCount;
  logic [2:0]  InstrCount_s;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic       a, r, inv, fl, zf, nf;
    logic [9:0] tgt;
    logic [7:0] off;
    logic       mem;
    int         wait_cyc;
    logic       ack_early;
    logic       halt;
    logic [9:0] exp_pc;
    int         exp_cnt;
  } vec_t;

  typedef struct {
    logic       is_done;
    logic [9:0] pc;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  prog_sequencer u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .AbsBranch(AbsBranch), .RelBranch(RelBranch),
    .BranchInvert(BranchInvert), .BranchFlag(BranchFlag), .ZeroFlag(ZeroFlag),
    .NegFlag(NegFlag), .AbsTarget(AbsTarget), .RelOffset(RelOffset), .MemReq(MemReq),
    .MemAck(MemAck), .HaltInstr(HaltInstr), .PC(PC), .IrLoad(IrLoad), .Commit(Commit),
    .Busy(Busy), .Done(Done), .InstrCount(InstrCount)
  );

  // Narrow-counter copy driven in lockstep to exercise saturation.
  prog_sequencer #(.PC_W(10), .CNT_W(3)) u_dut_sat (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .AbsBranch(AbsBranch), .RelBranch(RelBranch),
    .BranchInvert(BranchInvert), .BranchFlag(BranchFlag), .ZeroFlag(ZeroFlag),
    .NegFlag(NegFlag), .AbsTarget(AbsTarget), .RelOffset(RelOffset), .MemReq(MemReq),
    .MemAck(MemAck), .HaltInstr(HaltInstr), .PC(PC_s), .IrLoad(IrLoad_s), .Commit(Commit_s),
    .Busy(Busy_s), .Done(Done_s), .InstrCount(InstrCount_s)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic a, logic r, logic inv, logic fl, logic zf, logic nf,
                              logic [9:0] tgt, logic [7:0] off, logic mem, int w,
                              logic ack, logic halt, logic [9:0] ep, int ec);
    vec_t v;
    v.a = a; v.r = r; v.inv = inv; v.fl = fl; v.zf = zf; v.nf = nf;
    v.tgt = tgt; v.off = off; v.mem = mem; v.wait_cyc = w; v.ack_early = ack;
    v.halt = halt; v.exp_pc = ep; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic vec_t nop(logic [9:0] ep);
    return mk(0, 0, 0, 0, 0, 0, 10'h0, 8'h0, 0, 0, 0, 0, ep, 0);
  endfunction

  function automatic vec_t hlt(logic [9:0] ep, int ec);
    return mk(0, 0, 0, 0, 0, 0, 10'h0, 8'h0, 0, 0, 0, 1, ep, ec);
  endfunction

  function automatic exp_t ef(logic [9:0] pc);
    exp_t e;
    e.is_done = 1'b0; e.pc = pc; e.cnt = 0;
    return e;
  endfunction

  task automatic clear_inputs();
    AbsBranch = 0; RelBranch = 0; BranchInvert = 0; BranchFlag = 0; ZeroFlag = 0;
    NegFlag = 0; AbsTarget = '0; RelOffset = '0; MemReq = 0; MemAck = 0; HaltInstr = 0;
  endtask

  // Issue one instruction during its FETCH cycle and walk it through EXEC (and MEMWAIT).
  task automatic exec_vec(input vec_t v);
    int   n = 0;
    exp_t e;
    while (!IrLoad && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!IrLoad) begin
      chk("fetch_timeout", 0, 1);
      return;
    end
    AbsBranch = v.a; RelBranch = v.r; BranchInvert = v.inv; BranchFlag = v.fl;
    ZeroFlag = v.zf; NegFlag = v.nf; AbsTarget = v.tgt; RelOffset = v.off;
    MemReq = v.mem; HaltInstr = v.halt; MemAck = v.ack_early;
    e.is_done = v.halt; e.pc = v.exp_pc; e.cnt = v.exp_cnt;
    sb.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    chk("commit_exec", Commit, !v.halt);
    @(posedge Clk);
    #1 clear_inputs();
    if (v.mem) begin
      for (int i = 0; i < v.wait_cyc; i++) begin
        @(negedge Clk);
        chk("memwait_commit", Commit, 0);
        chk("memwait_pc", PC, v.exp_pc - 10'd1);
        chk("memwait_busy", Busy, 1);
        if (i == v.wait_cyc - 1) MemAck = 1;
        @(posedge Clk);
        #1 MemAck = 0;
      end
    end
  endtask

  // Monitor: pops an expectation on every fetch and on every rising Done.
  logic done_prev = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n) begin
      if (Busy) chk("irload_commit_excl", IrLoad & Commit, 0);
      if (IrLoad) begin
        if (sb.size() == 0) begin
          chk("fetch_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("fetch_kind", e.is_done, 0);
          chk("fetch_pc", PC, e.pc);
        end
      end
      if (Done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", e.is_done, 1);
          chk("done_pc", PC, e.pc);
          chk("done_count", InstrCount, e.cnt);
          chk("sat_done", Done_s, 1);
          chk("sat_busy", Busy_s, 0);
          chk("sat_pc", PC_s, e.pc);
          chk("sat_count", InstrCount_s, (e.cnt > 7) ? 7 : e.cnt);
        end
      end
    end
    if (Busy_s) chk("sat_excl", IrLoad_s & Commit_s, 0);
    done_prev <= Done;
  end

  initial begin
    Reset_n = 0;
    Start   = 0;
    clear_inputs();
    repeat (2) @(negedge Clk);
    chk("rst_pc", PC, 0);
    chk("rst_cnt", InstrCount, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_irload", IrLoad, 0);
    Reset_n = 1;
    @(negedge Clk);
    chk("idle_busy", Busy, 0);

    // Run A: three plain instructions then halt.
    sb.push_back(ef(10'd0));
    Start = 1;
    vecs = {nop(10'd1), nop(10'd2), nop(10'd3), hlt(10'd3, 4)};
    foreach (vecs[i]) exec_vec(vecs[i]);
    // Start held: DONE must persist.
    repeat (3) @(negedge Clk);
    chk("done_hold", Done, 1);
    chk("done_hold_pc", PC, 3);
    chk("done_hold_cnt", InstrCount, 4);
    Start = 0;
    @(posedge Clk);
    #1;
    chk("idle_after_done", Done, 0);
    chk("idle_after_done_busy", Busy, 0);

    // Run B: branches, wrap, memory wait; count must restart from zero.
    sb.push_back(ef(10'd0));
    Start = 1;
    @(posedge Clk);
    #1;
    chk("restart_cnt", InstrCount, 0);
    chk("restart_pc", PC, 0);
    chk("restart_busy", Busy, 1);
    vecs = {nop(10'd1), nop(10'd2), nop(10'd3), nop(10'd4), nop(10'd5),
            mk(1, 0, 1, 0, 1, 0, 10'h040, 8'h00, 0, 0, 0, 0, 10'd6, 0),
            mk(0, 1, 0, 1, 0, 1, 10'h000, 8'hFF, 0, 0, 0, 0, 10'd5, 0),
            mk(1, 0, 0, 0, 1, 0, 10'h040, 8'h00, 0, 0, 0, 0, 10'h040, 0),
            mk(1, 0, 0, 0, 1, 0, 10'h002, 8'h00, 0, 0, 0, 0, 10'd2, 0),
            mk(0, 1, 0, 1, 0, 1, 10'h000, 8'hFC, 0, 0, 0, 0, 10'd1022, 0),
            mk(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 0, 1, 0, 10'd1023, 0),
            nop(10'd0),
            mk(1, 1, 0, 0, 1, 0, 10'h123, 8'h10, 0, 0, 0, 0, 10'h123, 0),
            mk(0, 1, 0, 1, 0, 0, 10'h000, 8'h10, 0, 0, 0, 0, 10'h124, 0),
            mk(0, 1, 1, 0, 0, 0, 10'h000, 8'h7F, 0, 0, 0, 0, 10'h1A3, 0),
            mk(0, 0, 0, 0, 0, 0, 10'h000, 8'h00, 1, 3, 0, 0, 10'h1A4, 0),
            hlt(10'h1A4, 17)};
    foreach (vecs[i]) exec_vec(vecs[i]);
    @(negedge Clk);
    chk("runb_done", Done, 1);
    Start = 0;
    @(posedge Clk);
    #1;

    // Run C: asynchronous reset while waiting on memory.
    sb.push_back(ef(10'd0));
    Start = 1;
    vecs = {nop(10'd1), nop(10'd2)};
    foreach (vecs[i]) exec_vec(vecs[i]);
    MemReq = 1;
    @(posedge Clk);
    @(posedge Clk);
    #1 MemReq = 0;
    @(negedge Clk);
    chk("memwait_pre_busy", Busy, 1);
    chk("memwait_pre_cnt", InstrCount, 2);
    #2 Reset_n = 0;
    #1;
    chk("async_pc", PC, 0);
    chk("async_cnt", InstrCount, 0);
    chk("async_busy", Busy, 0);
    chk("async_done", Done, 0);
    chk("async_irload", IrLoad, 0);
    chk("async_commit", Commit, 0);
    sb.delete();
    sb.push_back(ef(10'd0));
    @(negedge Clk);
    Reset_n = 1;
    vecs = {nop(10'd1), hlt(10'd1, 2)};
    foreach (vecs[i]) exec_vec(vecs[i]);
    Start = 0;
    repeat (3) @(negedge Clk);
    chk("final_idle_done", Done, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
